// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame sender slice.
//   - FSM state encodings used by uart_frame_sender
//   - frame header bytes
//   - baud divider helper (integer truncation of CLK_FREQ / UART_BPS)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR0   = 3'd1;
    localparam logic [2:0] ST_HDR1   = 3'd2;
    localparam logic [2:0] ST_PAY    = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_STREAM = 3'd6;

    localparam logic [7:0] HDR_B0 = 8'hA5;
    localparam logic [7:0] HDR_B1 = 8'h5A;

    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// 8N1 serializer: start bit, 8 data bits LSB first, one stop bit, each bit
// held for BAUD_DIV clocks.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   load  in   load din and start a character (honoured only while idle)
//   din   in   byte to send
//   txd   out  serial line, idle high
//   busy  out  a character is on the wire
//   done  out  1-cycle pulse at the end of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int BAUD_DIV = 1736
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;

    // Shift register holds {stop, data, start}; bit 0 is what is on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (load) begin
                    shreg    <= {1'b1, din, 1'b0};
                    busy     <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            end else if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

    // Gated by busy so an asynchronous reset returns the line high at once.
    assign txd = busy ? shreg[0] : 1'b1;

endmodule

// File: rtl/uart_frame_sender.sv
// ---------------------------------------------------------------------------
// uart_frame_sender
// UART transmit controller: sends a framed burst [A5][5A][payload][sum8] or an
// unframed byte stream pulled from an upstream sample FIFO, over 8N1.
// Ports:
//   in_clk          in   system clock
//   in_rst          in   asynchronous active-low reset
//   in_start        in   rising edge starts one frame (ignored while busy)
//   in_frame_len    in   payload byte count, sampled on accepted start
//   in_stream_mode  in   level: continuous unframed send
//   in_abort        in   pulse: stop after the byte currently on the wire
//   in_data         in   payload byte, valid the cycle after out_data_req
//   out_data_req    out  1-cycle FIFO read strobe
//   out_uart_txd    out  serial output, idle high
//   out_busy        out  high while not IDLE
//   out_byte_done   out  1-cycle pulse when a stop bit completes
//   out_frame_done  out  1-cycle pulse after the last byte of a full frame
//   out_payload_cnt out  payload bytes fully sent in the current frame
// ---------------------------------------------------------------------------
module uart_frame_sender
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 200000000,
    parameter int UART_BPS = 115200,
    parameter int LEN_W    = 10,
    parameter int HDR_EN   = 1,
    parameter int CSUM_EN  = 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [LEN_W-1:0] in_frame_len,
    input  logic             in_stream_mode,
    input  logic             in_abort,
    input  logic [7:0]       in_data,
    output logic             out_data_req,
    output logic             out_uart_txd,
    output logic             out_busy,
    output logic             out_byte_done,
    output logic             out_frame_done,
    output logic [LEN_W-1:0] out_payload_cnt
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BPS);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       after_hdr;
    logic [2:0]       after_pay;
    logic             issue;
    logic             start_q;
    logic             start_edge;
    logic             accept;
    logic             req_d;
    logic             tx_load;
    logic [7:0]       tx_din;
    logic [7:0]       csum;
    logic [7:0]       csum_tx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pay_len;
    logic [LEN_W-1:0] cnt_next;
    logic             abort_pend;
    logic             abort_now;
    logic             in_flight;
    logic             fetch_state;
    logic             core_load;
    logic [7:0]       core_din;
    logic             core_busy;
    logic             core_done;

    assign start_edge  = in_start & ~start_q;
    assign accept      = (state == ST_IDLE) && start_edge && !in_abort;
    assign fetch_state = (state == ST_PAY) || (state == ST_STREAM);
    assign cnt_next    = out_payload_cnt + LEN_W'(1);

    // Fetched payload goes straight into the core the cycle it is valid.
    assign core_load = tx_load | (req_d & fetch_state);
    assign core_din  = (req_d & fetch_state) ? in_data : tx_din;

    // Abort only lands when nothing is on the wire or about to be loaded,
    // so a character is never truncated.
    assign in_flight = core_busy | core_load | out_data_req | req_d | tx_load;
    assign abort_now = (in_abort | abort_pend) & ~in_flight;

    // Headerless start with len=0 must send a zero checksum, not a stale one.
    assign csum_tx = (state == ST_IDLE) ? 8'h00 : csum;

    // Next-state logic; 'issue' marks that state_nxt must start a new byte.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pay_len   = (state == ST_IDLE) ? in_frame_len : len_q;
        after_pay = (CSUM_EN != 0) ? ST_CSUM : ST_DONE;
        if (pay_len != '0) begin
            after_hdr = ST_PAY;
        end else begin
            after_hdr = after_pay;
        end
        if (state == ST_IDLE) begin
            if (accept) begin
                state_nxt = (HDR_EN != 0) ? ST_HDR0 : after_hdr;
                issue     = 1'b1;
            end else if (in_stream_mode) begin
                state_nxt = ST_STREAM;
                issue     = 1'b1;
            end
        end else if (abort_now) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_HDR0: if (core_done) begin
                    state_nxt = ST_HDR1;
                    issue     = 1'b1;
                end
                ST_HDR1: if (core_done) begin
                    state_nxt = after_hdr;
                    issue     = 1'b1;
                end
                ST_PAY: if (core_done) begin
                    state_nxt = (cnt_next == len_q) ? after_pay : ST_PAY;
                    issue     = 1'b1;
                end
                ST_CSUM: if (core_done) begin
                    state_nxt = ST_DONE;
                    issue     = 1'b1;
                end
                ST_STREAM: if (core_done) begin
                    if (in_stream_mode) begin
                        issue = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register plus the per-byte strobes derived from the transition.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state          <= ST_IDLE;
            start_q        <= 1'b0;
            out_data_req   <= 1'b0;
            req_d          <= 1'b0;
            tx_load        <= 1'b0;
            tx_din         <= 8'h00;
            out_frame_done <= 1'b0;
            abort_pend     <= 1'b0;
        end else begin
            state          <= state_nxt;
            start_q        <= in_start;
            req_d          <= out_data_req;
            out_data_req   <= issue && ((state_nxt == ST_PAY) || (state_nxt == ST_STREAM));
            tx_load        <= issue && ((state_nxt == ST_HDR0) || (state_nxt == ST_HDR1) ||
                                        (state_nxt == ST_CSUM));
            tx_din         <= (state_nxt == ST_HDR0) ? HDR_B0 :
                              (state_nxt == ST_HDR1) ? HDR_B1 : csum_tx;
            out_frame_done <= (state_nxt == ST_DONE) && (state != ST_DONE);
            if (state_nxt == ST_IDLE) begin
                abort_pend <= 1'b0;
            end else if (state != ST_IDLE && in_abort) begin
                abort_pend <= 1'b1;
            end
        end
    end

    // Frame bookkeeping: length, checksum and payload progress.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            len_q           <= '0;
            csum            <= 8'h00;
            out_payload_cnt <= '0;
        end else if (accept) begin
            len_q           <= in_frame_len;
            csum            <= 8'h00;
            out_payload_cnt <= '0;
        end else begin
            if (req_d && state == ST_PAY) begin
                csum <= csum + in_data;
            end
            if (core_done && state == ST_PAY) begin
                out_payload_cnt <= cnt_next;
            end
        end
    end

    assign out_busy      = (state != ST_IDLE);
    assign out_byte_done = core_done;

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_core (
        .clk   (in_clk),
        .rst_n (in_rst),
        .load  (core_load),
        .din   (core_din),
        .txd   (out_uart_txd),
        .busy  (core_busy),
        .done  (core_done)
    );

endmodule

// File: tb/tb_uart_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_sender
// Directed bench for uart_frame_sender at BAUD_DIV=10. A line receiver
// decodes every character and pops the expected wire byte from a scoreboard
// queue; a FIFO model answers data requests from a payload queue.
// ---------------------------------------------------------------------------
module tb_uart_frame_sender;

    localparam int BAUD_DIV = 10;
    localparam int LEN_W    = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             stream_mode = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             data_req;
    logic             txd;
    logic             busy;
    logic             byte_done;
    logic             frame_done;
    logic [LEN_W-1:0] payload_cnt;

    int check_count = 0;
    int error_count = 0;
    int req_count = 0;
    int frame_done_count = 0;
    int byte_done_count = 0;
    bit rx_enable = 1'b1;

    logic [7:0] exp_wire[$];
    logic [7:0] payload_src[$];

    always #5 clk = ~clk;

    uart_frame_sender #(
        .CLK_FREQ (1000000),
        .UART_BPS (100000),
        .LEN_W    (LEN_W),
        .HDR_EN   (1),
        .CSUM_EN  (1)
    ) dut (
        .in_clk          (clk),
        .in_rst          (rst_n),
        .in_start        (start),
        .in_frame_len    (frame_len),
        .in_stream_mode  (stream_mode),
        .in_abort        (abort),
        .in_data         (data),
        .out_data_req    (data_req),
        .out_uart_txd    (txd),
        .out_busy        (busy),
        .out_byte_done   (byte_done),
        .out_frame_done  (frame_done),
        .out_payload_cnt (payload_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [LEN_W-1:0] len);
        @(negedge clk);
        frame_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic waitBytes(input string tag, input int target, input int max_cycles);
        int n = 0;
        while (byte_done_count < target && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_bytes_reached"}, 32'(byte_done_count >= target), 32'd1);
    endtask

    // Upstream FIFO model and event counters, sampled mid-cycle.
    initial begin : fifo_model
        forever begin
            @(negedge clk);
            if (data_req === 1'b1) begin
                req_count++;
                if (payload_src.size() > 0) begin
                    data = payload_src.pop_front();
                end else begin
                    data = 8'hEE;
                end
            end
            if (frame_done === 1'b1) frame_done_count++;
            if (byte_done === 1'b1) byte_done_count++;
        end
    end

    // Line receiver: samples mid-bit and checks against the scoreboard.
    initial begin : rx_monitor
        logic [7:0] rx_byte;
        logic       start_bit;
        logic       stop_bit;
        forever begin
            @(negedge txd);
            repeat (BAUD_DIV / 2) @(negedge clk);
            start_bit = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD_DIV) @(negedge clk);
                rx_byte[i] = txd;
            end
            repeat (BAUD_DIV) @(negedge clk);
            stop_bit = txd;
            if (rx_enable) begin
                checkOutput("rx_start_bit", 32'(start_bit), 32'd0);
                checkOutput("rx_stop_bit", 32'(stop_bit), 32'd1);
                if (exp_wire.size() == 0) begin
                    checkOutput("rx_unexpected_byte", 32'(exp_wire.size()), 32'd1);
                end else begin
                    checkOutput("rx_byte", 32'(rx_byte), 32'(exp_wire.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", error_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int r0;
        int f0;
        int b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_txd", 32'(txd), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_data_req", 32'(data_req), 32'd0);
        checkOutput("reset_byte_done", 32'(byte_done), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_payload_cnt", 32'(payload_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] frame len=3");
        r0 = req_count; f0 = frame_done_count;
        payload_src = '{8'h01, 8'h02, 8'h03};
        exp_wire = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h06};
        applyStimulus(3);
        checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
        waitIdle("t1", 3000);
        checkOutput("t1_reqs", 32'(req_count - r0), 32'd3);
        checkOutput("t1_frame_done", 32'(frame_done_count - f0), 32'd1);
        checkOutput("t1_payload_cnt", 32'(payload_cnt), 32'd3);
        checkOutput("t1_wire_left", 32'(exp_wire.size()), 32'd0);

        $display("[TB] frame len=0");
        r0 = req_count; f0 = frame_done_count;
        exp_wire = '{8'hA5, 8'h5A, 8'h00};
        applyStimulus(0);
        waitIdle("t2", 2000);
        checkOutput("t2_reqs", 32'(req_count - r0), 32'd0);
        checkOutput("t2_frame_done", 32'(frame_done_count - f0), 32'd1);
        checkOutput("t2_payload_cnt", 32'(payload_cnt), 32'd0);
        checkOutput("t2_wire_left", 32'(exp_wire.size()), 32'd0);

        $display("[TB] stream mode, 4 bytes");
        r0 = req_count; f0 = frame_done_count; b0 = byte_done_count;
        payload_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_wire = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        stream_mode = 1'b1;
        waitBytes("t3", b0 + 3, 2000);
        repeat (50) @(negedge clk);
        stream_mode = 1'b0;
        waitIdle("t3", 2000);
        checkOutput("t3_reqs", 32'(req_count - r0), 32'd4);
        checkOutput("t3_bytes", 32'(byte_done_count - b0), 32'd4);
        checkOutput("t3_frame_done", 32'(frame_done_count - f0), 32'd0);
        checkOutput("t3_wire_left", 32'(exp_wire.size()), 32'd0);

        $display("[TB] abort during payload byte 2 of len=5");
        r0 = req_count; f0 = frame_done_count; b0 = byte_done_count;
        payload_src = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        exp_wire = '{8'hA5, 8'h5A, 8'h10, 8'h20};
        applyStimulus(5);
        waitBytes("t4", b0 + 3, 2000);
        repeat (40) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitIdle("t4", 2000);
        checkOutput("t4_reqs", 32'(req_count - r0), 32'd2);
        checkOutput("t4_bytes", 32'(byte_done_count - b0), 32'd4);
        checkOutput("t4_frame_done", 32'(frame_done_count - f0), 32'd0);
        checkOutput("t4_payload_cnt", 32'(payload_cnt), 32'd2);
        checkOutput("t4_wire_left", 32'(exp_wire.size()), 32'd0);
        payload_src.delete();

        $display("[TB] held start and start while busy");
        r0 = req_count; f0 = frame_done_count;
        payload_src = '{8'h77};
        exp_wire = '{8'hA5, 8'h5A, 8'h77, 8'h77};
        @(negedge clk);
        frame_len = 1;
        start = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t5_busy_mid_frame", 32'(busy), 32'd1);
        waitIdle("t5", 2000);
        repeat (150) @(negedge clk);
        checkOutput("t5_no_retrigger", 32'(busy), 32'd0);
        checkOutput("t5_reqs", 32'(req_count - r0), 32'd1);
        checkOutput("t5_frame_done", 32'(frame_done_count - f0), 32'd1);
        checkOutput("t5_wire_left", 32'(exp_wire.size()), 32'd0);

        $display("[TB] reset mid-byte then clean frame");
        rx_enable = 1'b0;
        payload_src = '{8'hAA, 8'hBB};
        applyStimulus(2);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_txd", 32'(txd), 32'd1);
        checkOutput("t6_reset_busy", 32'(busy), 32'd0);
        checkOutput("t6_reset_payload_cnt", 32'(payload_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        payload_src.delete();
        exp_wire.delete();
        rx_enable = 1'b1;
        r0 = req_count; f0 = frame_done_count;
        payload_src = '{8'hC1, 8'hC2};
        exp_wire = '{8'hA5, 8'h5A, 8'hC1, 8'hC2, 8'h83};
        applyStimulus(2);
        waitIdle("t6", 3000);
        checkOutput("t6_reqs", 32'(req_count - r0), 32'd2);
        checkOutput("t6_frame_done", 32'(frame_done_count - f0), 32'd1);
        checkOutput("t6_payload_cnt", 32'(payload_cnt), 32'd2);
        checkOutput("t6_wire_left", 32'(exp_wire.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
